// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian crossing controller.
// Holds the phase enum, default timing constants and a helper that sizes
// the grant-index field from the channel count.
package ped_pkg;

    typedef enum logic [1:0] {
        DONT_WALK = 2'd0,
        WALK      = 2'd1,
        FLASH     = 2'd2
    } ped_state_t;

    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_WALK_TIME   = 50;
    localparam int unsigned DEF_FLASH_TIME  = 20;
    localparam int unsigned DEF_FLASH_HALF  = 5;
    localparam int unsigned DEF_MIN_DW_TIME = 150;
    localparam int unsigned DEF_TIMER_W     = 16;

    // A single channel still needs a 1-bit index field.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ped_rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   i_req   - request vector, one bit per crossing
//   i_last  - index of the previously granted crossing
//   o_grant - first requesting index found searching upward from i_last+1
//   o_valid - 1 when any request is present
module ped_rr_arbiter
    import ped_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last,
    output logic [IDX_W-1:0]  o_grant,
    output logic              o_valid
);

    always_comb begin
        int unsigned idx;
        logic [NUM_CH-1:0] w_sh;
        idx     = 0;
        w_sh    = '0;
        o_grant = '0;
        o_valid = 1'b0;
        // Offsets 1..NUM_CH visit every channel once, ending on i_last itself.
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            idx  = (32'(i_last) + off) % NUM_CH;
            w_sh = i_req >> idx;
            if (!o_valid && w_sh[0]) begin
                o_grant = IDX_W'(idx);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: latches button presses per crossing and
// serves them one at a time round-robin through DONT_WALK -> WALK -> FLASH.
// Ports:
//   clk       - clock, all state changes on rising edge
//   reset     - synchronous active-low reset
//   ped_req   - per-crossing push button (NUM_CH)
//   hold      - blocks new WALK grants and cuts an active WALK short
//   walk      - walk lamps, at most one bit set (NUM_CH)
//   dont_walk - don't-walk lamps, flashing on the granted crossing in FLASH
//   pending   - latched request lamps (NUM_CH)
//   phase     - 0 DONT_WALK, 1 WALK, 2 FLASH
module ped_crossing_ctrl
    import ped_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned WALK_TIME   = DEF_WALK_TIME,
    parameter int unsigned FLASH_TIME  = DEF_FLASH_TIME,
    parameter int unsigned FLASH_HALF  = DEF_FLASH_HALF,
    parameter int unsigned MIN_DW_TIME = DEF_MIN_DW_TIME,
    parameter int unsigned TIMER_W     = DEF_TIMER_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ped_req,
    input  logic              hold,
    output logic [NUM_CH-1:0] walk,
    output logic [NUM_CH-1:0] dont_walk,
    output logic [NUM_CH-1:0] pending,
    output logic [1:0]        phase
);

    localparam int unsigned IDX_W = idx_width(NUM_CH);
    localparam logic [63:0] T_LIM = 64'd1 << TIMER_W;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH must be in 1..16");
    end
    if (WALK_TIME < 1 || FLASH_TIME < 1 || FLASH_HALF < 1 || MIN_DW_TIME < 1) begin : g_bad_time
        $error("time parameters must be at least 1");
    end
    if (64'(WALK_TIME) >= T_LIM || 64'(FLASH_TIME) >= T_LIM ||
        64'(FLASH_HALF) >= T_LIM || 64'(MIN_DW_TIME) >= T_LIM) begin : g_bad_timer_w
        $error("time parameters must fit in TIMER_W bits");
    end

    ped_state_t          r_state, w_state_n;
    logic [TIMER_W-1:0]  r_timer, w_timer_n;
    logic [IDX_W-1:0]    r_grant, w_grant_n;
    logic [NUM_CH-1:0]   r_pending, w_clr;

    logic [IDX_W-1:0]    w_arb_grant;
    logic                w_arb_valid;
    logic [NUM_CH-1:0]   w_grant_oh;
    logic [TIMER_W-1:0]  w_flash_step;
    logic                w_flash_lit;

    ped_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .i_req   (r_pending),
        .i_last  (r_grant),
        .o_grant (w_arb_grant),
        .o_valid (w_arb_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= DONT_WALK;
            r_timer   <= '0;
            r_grant   <= IDX_W'(NUM_CH - 1);
            r_pending <= '0;
        end else begin
            r_state   <= w_state_n;
            r_timer   <= w_timer_n;
            r_grant   <= w_grant_n;
            // A press in the grant cycle wins over the clear.
            r_pending <= (r_pending & ~w_clr) | ped_req;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer + TIMER_W'(1);
        w_grant_n = r_grant;
        w_clr     = '0;
        case (r_state)
            DONT_WALK: begin
                if (r_timer == TIMER_W'(MIN_DW_TIME - 1)) begin
                    if (w_arb_valid && !hold) begin
                        w_state_n = WALK;
                        w_timer_n = '0;
                        w_grant_n = w_arb_grant;
                        w_clr     = NUM_CH'(1) << w_arb_grant;
                    end else begin
                        w_timer_n = r_timer;
                    end
                end
            end
            WALK: begin
                if (hold || r_timer == TIMER_W'(WALK_TIME - 1)) begin
                    w_state_n = FLASH;
                    w_timer_n = '0;
                end
            end
            FLASH: begin
                if (r_timer == TIMER_W'(FLASH_TIME - 1)) begin
                    w_state_n = DONT_WALK;
                    w_timer_n = '0;
                end
            end
            default: begin
                w_state_n = DONT_WALK;
                w_timer_n = '0;
            end
        endcase
    end

    assign w_grant_oh   = NUM_CH'(1) << r_grant;
    assign w_flash_step = r_timer / TIMER_W'(FLASH_HALF);
    assign w_flash_lit  = ~w_flash_step[0];

    always_comb begin
        walk      = '0;
        dont_walk = '1;
        case (r_state)
            WALK: begin
                walk      = w_grant_oh;
                dont_walk = ~w_grant_oh;
            end
            FLASH: begin
                dont_walk = ~w_grant_oh | (w_flash_lit ? w_grant_oh : '0);
            end
            default: ;
        endcase
    end

    assign pending = r_pending;
    assign phase   = r_state;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: a 4-channel and a 1-channel instance run side
// by side against a cycle-counting behavioural model, with directed scenarios
// followed by random traffic.
module tb_ped_crossing_ctrl;

    localparam int WT = 5;
    localparam int FT = 4;
    localparam int FH = 1;
    localparam int MD = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ped_req4;
    logic [0:0] ped_req1;
    logic       hold;
    logic [3:0] walk4, dw4, pend4;
    logic [0:0] walk1, dw1, pend1;
    logic [1:0] ph4, ph1;

    always #5 clk = ~clk;

    ped_crossing_ctrl #(
        .NUM_CH(4), .WALK_TIME(WT), .FLASH_TIME(FT), .FLASH_HALF(FH),
        .MIN_DW_TIME(MD), .TIMER_W(8)
    ) u_dut4 (
        .clk(clk), .reset(reset), .ped_req(ped_req4), .hold(hold),
        .walk(walk4), .dont_walk(dw4), .pending(pend4), .phase(ph4)
    );

    ped_crossing_ctrl #(
        .NUM_CH(1), .WALK_TIME(WT), .FLASH_TIME(FT), .FLASH_HALF(FH),
        .MIN_DW_TIME(MD), .TIMER_W(8)
    ) u_dut1 (
        .clk(clk), .reset(reset), .ped_req(ped_req1), .hold(hold),
        .walk(walk1), .dont_walk(dw1), .pending(pend1), .phase(ph1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Model: phase number, cycles already spent in this phase, pending set,
    // and the crossing served most recently.
    int        m_phase[2];
    int        m_elapsed[2];
    int        m_last[2];
    bit [15:0] m_pend[2];
    int        m_nch[2] = '{4, 1};

    function automatic void model_reset(input int m);
        m_phase[m]   = 0;
        m_elapsed[m] = 0;
        m_pend[m]    = '0;
        m_last[m]    = m_nch[m] - 1;
    endfunction

    function automatic void model_step(input int m, input bit rst_n, input bit [15:0] req, input bit hld);
        bit [15:0] np;
        int pick;
        int c;
        if (!rst_n) begin
            model_reset(m);
            return;
        end
        np   = m_pend[m] | req;
        pick = -1;
        case (m_phase[m])
            0: begin
                if (m_elapsed[m] >= MD - 1 && m_pend[m] != 0 && !hld) begin
                    for (int k = 1; k <= m_nch[m]; k++) begin
                        c = (m_last[m] + k) % m_nch[m];
                        if (pick < 0 && m_pend[m][c]) pick = c;
                    end
                    m_last[m]    = pick;
                    np[pick]     = req[pick];
                    m_phase[m]   = 1;
                    m_elapsed[m] = 0;
                end else m_elapsed[m]++;
            end
            1: begin
                if (hld || m_elapsed[m] + 1 == WT) begin
                    m_phase[m] = 2; m_elapsed[m] = 0;
                end else m_elapsed[m]++;
            end
            default: begin
                if (m_elapsed[m] + 1 == FT) begin
                    m_phase[m] = 0; m_elapsed[m] = 0;
                end else m_elapsed[m]++;
            end
        endcase
        m_pend[m] = np;
    endfunction

    function automatic bit [15:0] exp_walk(input int m);
        return (m_phase[m] == 1) ? (16'd1 << m_last[m]) : 16'd0;
    endfunction

    function automatic bit [15:0] exp_dw(input int m);
        bit [15:0] v;
        v = (16'd1 << m_nch[m]) - 16'd1;
        if (m_phase[m] == 1) v[m_last[m]] = 1'b0;
        if (m_phase[m] == 2 && ((m_elapsed[m] / FH) % 2) == 1) v[m_last[m]] = 1'b0;
        return v;
    endfunction

    logic [3:0] walk_log[$];
    logic [3:0] dw_log[$];
    logic [3:0] pend_log[$];
    logic [1:0] ph_log[$];
    int         grants[$];
    logic [3:0] prev_walk;

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_logs();
        walk_log.delete(); dw_log.delete(); pend_log.delete();
        ph_log.delete(); grants.delete();
        prev_walk = '0;
    endtask

    // One clock: compare the settled outputs, log them, then drive this
    // cycle's inputs and advance the model to the post-edge state.
    task automatic cycle(input bit rst_n, input bit [3:0] r4, input bit hld);
        bit r1;
        @(negedge clk);
        check("walk4",  {12'd0, walk4}, exp_walk(0));
        check("dw4",    {12'd0, dw4},   exp_dw(0));
        check("pend4",  {12'd0, pend4}, m_pend[0]);
        check("phase4", {14'd0, ph4},   16'(m_phase[0]));
        check("walk1",  {15'd0, walk1}, exp_walk(1));
        check("dw1",    {15'd0, dw1},   exp_dw(1));
        check("pend1",  {15'd0, pend1}, m_pend[1]);
        check("phase1", {14'd0, ph1},   16'(m_phase[1]));
        walk_log.push_back(walk4); dw_log.push_back(dw4);
        pend_log.push_back(pend4); ph_log.push_back(ph4);
        if (walk4 != 0 && prev_walk == 0) grants.push_back(oh_idx(walk4));
        prev_walk = walk4;
        r1 = ($urandom_range(0, 2) == 0);
        reset    = rst_n;
        ped_req4 = r4;
        ped_req1 = r1;
        hold     = hld;
        model_step(0, rst_n, {12'd0, r4}, hld);
        model_step(1, rst_n, {15'd0, r1}, hld);
    endtask

    task automatic do_reset();
        cycle(1'b0, 4'b0, 1'b0);
        cycle(1'b0, 4'b0, 1'b0);
        clear_logs();
    endtask

    int wcnt;
    bit [3:0] rq;
    bit       hl;

    initial begin
        reset = 1'b0; ped_req4 = '0; ped_req1 = '0; hold = 1'b0;
        model_reset(0); model_reset(1);
        prev_walk = '0;
        @(posedge clk);

        // Single request on crossing 1.
        do_reset();
        cycle(1'b1, 4'b0010, 1'b0);
        repeat (16) cycle(1'b1, 4'b0, 1'b0);
        check("s1_pend_c1", {12'd0, pend_log[1]}, 16'h0002);
        check("s1_walk_c2", {12'd0, walk_log[2]}, 16'h0000);
        for (int i = 3; i <= 7; i++) check("s1_walk", {12'd0, walk_log[i]}, 16'h0002);
        check("s1_walk_end", {12'd0, walk_log[8]}, 16'h0000);
        for (int i = 8; i <= 11; i++) check("s1_flash_dw1", {15'd0, dw_log[i][1]}, 16'((i - 8) % 2 == 0));
        check("s1_phase_back", {14'd0, ph_log[12]}, 16'h0000);

        // Three simultaneous requests, served 0,1,3.
        do_reset();
        cycle(1'b1, 4'b1011, 1'b0);
        repeat (45) cycle(1'b1, 4'b0, 1'b0);
        check("s2_ngrants", 16'(grants.size()), 16'd3);
        if (grants.size() == 3) begin
            check("s2_g0", 16'(grants[0]), 16'd0);
            check("s2_g1", 16'(grants[1]), 16'd1);
            check("s2_g2", 16'(grants[2]), 16'd3);
        end
        check("s2_pend_c3", {12'd0, pend_log[3]}, 16'h000a);
        check("s2_pend_c15", {12'd0, pend_log[15]}, 16'h0008);

        // hold cuts WALK short, then blocks the next WALK.
        do_reset();
        cycle(1'b1, 4'b0001, 1'b0);
        cycle(1'b1, 4'b0, 1'b0);
        cycle(1'b1, 4'b0, 1'b0);
        cycle(1'b1, 4'b0, 1'b0);
        cycle(1'b1, 4'b0100, 1'b1);
        repeat (20) cycle(1'b1, 4'b0, 1'b1);
        repeat (20) cycle(1'b1, 4'b0, 1'b0);
        wcnt = 0;
        for (int i = 0; i < 9; i++) if (walk_log[i] != 0) wcnt++;
        check("s3_walk_len", 16'(wcnt), 16'd2);
        for (int i = 5; i <= 8; i++) check("s3_flash", {14'd0, ph_log[i]}, 16'd2);
        for (int i = 9; i <= 25; i++) check("s3_held_dw", {14'd0, ph_log[i]}, 16'd0);
        check("s3_pend_held", {12'd0, pend_log[20]}, 16'h0004);
        check("s3_walk_after", {12'd0, walk_log[26]}, 16'h0004);

        // Press on crossing 2 in its own grant cycle.
        do_reset();
        cycle(1'b1, 4'b0100, 1'b0);
        cycle(1'b1, 4'b0, 1'b0);
        cycle(1'b1, 4'b0101, 1'b0);
        repeat (45) cycle(1'b1, 4'b0, 1'b0);
        check("s4_pend_c3", {12'd0, pend_log[3]}, 16'h0005);
        check("s4_ngrants", 16'(grants.size()), 16'd3);
        if (grants.size() == 3) begin
            check("s4_g0", 16'(grants[0]), 16'd2);
            check("s4_g1", 16'(grants[1]), 16'd0);
            check("s4_g2", 16'(grants[2]), 16'd2);
        end

        // Reset during FLASH discards everything.
        do_reset();
        cycle(1'b1, 4'b0001, 1'b0);
        repeat (8) cycle(1'b1, 4'b0, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0);
        cycle(1'b1, 4'b0010, 1'b0);
        repeat (6) cycle(1'b1, 4'b0, 1'b0);
        check("s5_in_flash", {14'd0, ph_log[9]}, 16'd2);
        check("s5_walk", {12'd0, walk_log[10]}, 16'h0000);
        check("s5_dw", {12'd0, dw_log[10]}, 16'h000f);
        check("s5_pend", {12'd0, pend_log[10]}, 16'h0000);
        check("s5_phase", {14'd0, ph_log[10]}, 16'd0);
        check("s5_early12", {12'd0, walk_log[12]}, 16'h0000);
        check("s5_walk13", {12'd0, walk_log[13]}, 16'h0002);

        // Random traffic.
        do_reset();
        hl = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) hl = ~hl;
            cycle($urandom_range(0, 199) != 0, rq, hl);
        end
        cycle(1'b1, 4'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
